// File: rtl/madgwick_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : madgwick_wb_bridge
// Purpose  : Wishbone slave front-end for the Madgwick filter core. Sensor
//            channels are staged by the CPU and pushed as sample vectors into
//            a FIFO. The FIFO streams to the filter over valid/ready, and the
//            filter results are captured into readable registers.
// Options  : MADGWICK_WB_IRQ_EN adds the irq_o port and the CTRL[6] irq_en bit.
// Revision : 1.0 - initial release
// ============================================================================
module madgwick_wb_bridge #(
  parameter int IN_CH      = 6,
  parameter int IN_W       = 16,
  parameter int OUT_CH     = 4,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADR_W      = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADR_W-1:0]          adr_i,
  input  logic [31:0]               dat_i,
  output logic [31:0]               dat_o,
  input  logic                      we_i,
  input  logic                      stb_i,
  input  logic                      cyc_i,
  output logic                      ack_o,
  output logic                      f_rst_n_o,
  output logic                      s_valid_o,
  output logic [IN_CH*IN_W-1:0]     s_data_o,
  input  logic                      s_ready_i,
  input  logic                      r_valid_i,
  input  logic [OUT_CH*OUT_W-1:0]   r_data_i,
  output logic                      r_ready_o
`ifdef MADGWICK_WB_IRQ_EN
  ,
  output logic                      irq_o
`endif
);

  localparam int AW         = ADR_W - 2;
  localparam int CW         = $clog2(FIFO_DEPTH);
  localparam int VW         = IN_CH * IN_W;
  localparam int STATUS_IDX = IN_CH + OUT_CH + 1;

  logic [AW-1:0]    widx;
  logic             req, wr, ctrl_wr, last_ch_wr;
  logic             en, start, done, auto_mode, ovf, irq_en;
  logic             en_next, done_next;
  logic             push_req, push_ok, push_drop, pop, full;
  logic             disable_evt, capture, pending, busy;
  logic [IN_W-1:0]  stage [IN_CH];
  logic [OUT_W-1:0] result [OUT_CH];
  logic [VW-1:0]    fifo_mem [FIFO_DEPTH];
  logic [VW-1:0]    push_vec;
  logic [CW-1:0]    wr_ptr, rd_ptr;
  logic [CW:0]      level;
  logic [15:0]      res_cnt;
  logic [31:0]      ctrl_val, rd_data;
  logic             unused_bits;

  assign widx        = adr_i[ADR_W-1:2];
  assign req         = stb_i & cyc_i & ~ack_o;
  assign wr          = req & we_i;
  assign ctrl_wr     = wr & (widx == '0);
  assign last_ch_wr  = wr & (widx == AW'(IN_CH));
  // A write that clears enable also vetoes any push it would trigger
  assign en_next     = ctrl_wr ? dat_i[0] : en;
  assign pop         = s_valid_o & s_ready_i;
  assign full        = (level == (CW+1)'(FIFO_DEPTH));
  assign push_req    = (ctrl_wr & dat_i[1] & ~start) | (last_ch_wr & auto_mode);
  assign push_ok     = push_req & en_next & (~full | pop);
  assign push_drop   = push_req & en_next & full & ~pop;
  assign disable_evt = en & ~en_next;
  assign capture     = r_valid_i & r_ready_o;
  assign busy        = (level != '0) | pending;
  // A capture always wins over any done-clearing event in the same cycle
  assign done_next   = capture |
                       (done & ~((push_req & en_next) | (ctrl_wr & ~dat_i[1]) | disable_evt));

  assign s_valid_o   = (level != '0) & en;
  assign s_data_o    = fifo_mem[rd_ptr];
  assign r_ready_o   = en;
  assign f_rst_n_o   = rst_n & en;
  assign ctrl_val    = {25'd0, irq_en, busy, ovf, auto_mode, done, start, en};
  assign unused_bits = ^{dat_i, adr_i[1:0]};

  // Staging vector as it will be after this write, so an auto push carries the new data
  always_comb begin
    push_vec = '0;
    for (int i = 0; i < IN_CH; i++) begin
      push_vec[i*IN_W +: IN_W] = (wr && widx == AW'(i+1)) ? dat_i[IN_W-1:0] : stage[i];
    end
  end

  // Read mux; unmapped words return zero
  always_comb begin
    rd_data = '0;
    if (widx == '0) rd_data = ctrl_val;
    for (int i = 0; i < IN_CH; i++) begin
      if (widx == AW'(i+1)) rd_data = 32'(signed'(stage[i]));
    end
    for (int j = 0; j < OUT_CH; j++) begin
      if (widx == AW'(IN_CH+1+j)) rd_data = 32'(signed'(result[j]));
    end
    if (widx == AW'(STATUS_IDX)) rd_data = {8'd0, res_cnt, 8'(level)};
  end

  // Single-cycle acknowledge with registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= req;
      dat_o <= (req & ~we_i) ? rd_data : '0;
    end
  end

  // Control bits, staging channels and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        <= 1'b0;
      start     <= 1'b0;
      done      <= 1'b0;
      auto_mode <= 1'b0;
      ovf       <= 1'b0;
      res_cnt   <= '0;
      for (int i = 0; i < IN_CH; i++) stage[i] <= '0;
      for (int j = 0; j < OUT_CH; j++) result[j] <= '0;
    end else begin
      en   <= en_next;
      done <= done_next;
      // start is held until the filter answers, then drops so the next 0->1 can re-arm
      if (ctrl_wr) start <= dat_i[1];
      else if (capture) start <= 1'b0;
      if (ctrl_wr) auto_mode <= dat_i[3];
      if (push_drop) ovf <= 1'b1;
      else if (ctrl_wr && dat_i[4]) ovf <= 1'b0;
      for (int i = 0; i < IN_CH; i++) begin
        if (wr && widx == AW'(i+1)) stage[i] <= dat_i[IN_W-1:0];
      end
      if (capture) begin
        for (int j = 0; j < OUT_CH; j++) result[j] <= r_data_i[j*OUT_W +: OUT_W];
        res_cnt <= res_cnt + 16'd1;
      end
    end
  end

  // Sample FIFO plus the outstanding-sample flag; disabling flushes both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      pending <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) fifo_mem[k] <= '0;
    end else if (disable_evt) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      pending <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= push_vec;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (CW+1)'(push_ok) - (CW+1)'(pop);
      if (pop) pending <= 1'b1;
      else if (capture) pending <= 1'b0;
    end
  end

`ifdef MADGWICK_WB_IRQ_EN
  // Interrupt enable bit and registered interrupt aligned with done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= dat_i[6];
      irq_o <= done_next & (ctrl_wr ? dat_i[6] : irq_en);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_madgwick_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_madgwick_wb_bridge
// Purpose  : Self-checking bench for madgwick_wb_bridge. It uses randomised
//            channel and result data, and a queue-based model of the bridge's
//            expected samples and registers.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_madgwick_wb_bridge;
  localparam int IN_CH = 6, IN_W = 16, OUT_CH = 4, OUT_W = 32, FIFO_DEPTH = 4, ADR_W = 6;
  localparam int VW = IN_CH * IN_W;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [ADR_W-1:0]        adr_i = '0;
  logic [31:0]             dat_i = '0;
  logic [31:0]             dat_o;
  logic                    we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0;
  logic                    ack_o;
  logic                    f_rst_n_o, s_valid_o, r_ready_o;
  logic [VW-1:0]           s_data_o;
  logic                    s_ready_i = 1'b0, r_valid_i = 1'b0;
  logic [OUT_CH*OUT_W-1:0] r_data_i = '0;
`ifdef MADGWICK_WB_IRQ_EN
  logic                    irq_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0]   m_stage [IN_CH];
  logic [31:0]   m_q [OUT_CH];
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] got_q [$];

  always #5 clk = ~clk;

  madgwick_wb_bridge #(
    .IN_CH(IN_CH), .IN_W(IN_W), .OUT_CH(OUT_CH), .OUT_W(OUT_W),
    .FIFO_DEPTH(FIFO_DEPTH), .ADR_W(ADR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
    .f_rst_n_o(f_rst_n_o), .s_valid_o(s_valid_o), .s_data_o(s_data_o),
    .s_ready_i(s_ready_i), .r_valid_i(r_valid_i), .r_data_i(r_data_i),
    .r_ready_o(r_ready_o)
`ifdef MADGWICK_WB_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  // Record every sample the filter side accepts
  always @(posedge clk) if (s_valid_o && s_ready_i) got_q.push_back(s_data_o);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [VW-1:0] vec();
    logic [VW-1:0] v;
    for (int i = 0; i < IN_CH; i++) v[i*IN_W +: IN_W] = m_stage[i];
    return v;
  endfunction

  task automatic bus(input logic [ADR_W-1:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rd);
    int k;
    adr_i = a; we_i = w; dat_i = d; stb_i = 1'b1; cyc_i = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!ack_o && k < 8);
    check("ack_latency", 128'(k), 128'(1));
    rd = dat_o;
    stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", 128'(ack_o), 128'(0));
  endtask

  task automatic wr(input logic [ADR_W-1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(a, 1'b1, d, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [ADR_W-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus(a, 1'b0, 32'd0, d);
    check(tag, 128'(d), 128'(exp));
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] rdv;
    for (int i = 0; i < IN_CH; i++) m_stage[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 128'(ack_o), 128'(0));
    check("rst_dat", 128'(dat_o), 128'(0));
    check("rst_svalid", 128'(s_valid_o), 128'(0));
    check("rst_rready", 128'(r_ready_o), 128'(0));
    check("rst_frst", 128'(f_rst_n_o), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_ctrl", 6'h00, 32'h0);
    rd_chk("rst_status", 6'h2C, 32'h0);

    // Enable, staging readback with sign extension, unmapped access
    wr(6'h00, 32'h1);
    check("en_frst", 128'(f_rst_n_o), 128'(1));
    check("en_rready", 128'(r_ready_o), 128'(1));
    for (int i = 0; i < IN_CH; i++) begin
      d = $urandom;
      wr(6'((i+1)*4), d);
      m_stage[i] = d[15:0];
    end
    for (int i = 0; i < IN_CH; i++) rd_chk("stage_rand", 6'((i+1)*4), sext(m_stage[i]));
    wr(6'h04, 32'h7B8);     m_stage[0] = 16'h07B8;
    wr(6'h18, 32'h3F54);    m_stage[5] = 16'h3F54;
    wr(6'h08, 32'hFFFF8000); m_stage[1] = 16'h8000;
    rd_chk("stage_04", 6'h04, 32'h000007B8);
    rd_chk("stage_18", 6'h18, 32'h00003F54);
    rd_chk("stage_neg", 6'h08, 32'hFFFF8000);
    wr(6'h30, 32'hFFFFFFFF);
    rd_chk("unmapped", 6'h30, 32'h0);
    rd_chk("ctrl_after_unmapped", 6'h00, 32'h1);

    // Single-shot push, delayed filter acceptance, directed result
    wr(6'h00, 32'h3);
    exp_q.push_back(vec());
    check("push_valid", 128'(s_valid_o), 128'(1));
    check("push_data", 128'(s_data_o), 128'(vec()));
    repeat (3) @(posedge clk);
    #1 s_ready_i = 1'b1;
    @(posedge clk); #1 s_ready_i = 1'b0;
    check("pop_valid_low", 128'(s_valid_o), 128'(0));
    bus(6'h00, 1'b0, 32'd0, rdv);
    check("busy_pending", 128'(rdv[5]), 128'(1));
    m_q[0] = 32'h40000000; m_q[1] = 0; m_q[2] = 0; m_q[3] = 0;
    r_data_i = {m_q[3], m_q[2], m_q[1], m_q[0]};
    r_valid_i = 1'b1;
    @(posedge clk); #1 r_valid_i = 1'b0;
    rd_chk("ctrl_done", 6'h00, 32'h5);
    rd_chk("res_qw", 6'h1C, 32'h40000000);
    rd_chk("status_cnt1", 6'h2C, 32'h00000100);

    // Second shot with random result data
    wr(6'h00, 32'h1);
    wr(6'h00, 32'h3);
    exp_q.push_back(vec());
    s_ready_i = 1'b1;
    @(posedge clk); #1 s_ready_i = 1'b0;
    for (int j = 0; j < OUT_CH; j++) m_q[j] = $urandom;
    r_data_i = {m_q[3], m_q[2], m_q[1], m_q[0]};
    r_valid_i = 1'b1;
    @(posedge clk); #1 r_valid_i = 1'b0;
    for (int j = 0; j < OUT_CH; j++) rd_chk("res_rand", 6'((IN_CH+1+j)*4), m_q[j]);
    rd_chk("status_cnt2", 6'h2C, 32'h00000200);
    rd_chk("ctrl_done2", 6'h00, 32'h5);

    // Auto mode, FIFO fill and overflow, ordered drain
    wr(6'h00, 32'h9);
    rd_chk("ctrl_auto", 6'h00, 32'h9);
    d = $urandom;
    wr(6'h04, d); m_stage[0] = d[15:0];
    rd_chk("auto_nonlast_nopush", 6'h2C, 32'h00000200);
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      wr(6'h18, d);
      m_stage[5] = d[15:0];
      if (exp_q.size() < 2 + FIFO_DEPTH) exp_q.push_back(vec());
    end
    rd_chk("status_full", 6'h2C, 32'h00000204);
    rd_chk("ctrl_ovf", 6'h00, 32'h39);
    wr(6'h00, 32'h19);
    rd_chk("ctrl_ovf_clr", 6'h00, 32'h29);
    s_ready_i = 1'b1;
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) @(posedge clk);
    #1 s_ready_i = 1'b0;
    check("pop_count", 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("sample_order", 128'(got_q[i]), 128'(exp_q[i]));
    rd_chk("status_drained", 6'h2C, 32'h00000200);

    // Disable flushes FIFO, keeps results; pushes and results ignored while disabled
    wr(6'h18, 32'h1234);
    wr(6'h18, 32'h5678);
    rd_chk("status_two", 6'h2C, 32'h00000202);
    wr(6'h00, 32'h0);
    check("dis_svalid", 128'(s_valid_o), 128'(0));
    check("dis_frst", 128'(f_rst_n_o), 128'(0));
    check("dis_rready", 128'(r_ready_o), 128'(0));
    rd_chk("dis_status", 6'h2C, 32'h00000200);
    rd_chk("dis_ctrl", 6'h00, 32'h0);
    rd_chk("dis_res", 6'h1C, m_q[0]);
    wr(6'h00, 32'h2);
    rd_chk("dis_push_ignored", 6'h2C, 32'h00000200);
    rd_chk("dis_no_ovf", 6'h00, 32'h2);
    r_data_i = '1;
    r_valid_i = 1'b1;
    @(posedge clk); #1 r_valid_i = 1'b0;
    rd_chk("dis_res_kept", 6'h20, m_q[1]);

    // Asynchronous reset in the middle of a read
    adr_i = 6'h2C; we_i = 1'b0; stb_i = 1'b1; cyc_i = 1'b1;
    @(posedge clk); #1;
    check("midrd_ack_up", 128'(ack_o), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    check("midrd_ack_drop", 128'(ack_o), 128'(0));
    check("midrd_dat_zero", 128'(dat_o), 128'(0));
    stb_i = 1'b0; cyc_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("post_rst_ctrl", 6'h00, 32'h0);
    rd_chk("post_rst_status", 6'h2C, 32'h0);
    rd_chk("post_rst_res", 6'h1C, 32'h0);
    rd_chk("post_rst_stage", 6'h04, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
